// File: rtl/seven_segment_scan_driver_pkg.sv
// Shared types and defaults for the seven-segment scan driver.
// Holds the slot FSM encoding, default timing values and a width helper.
package seven_segment_scan_driver_pkg;

    typedef enum logic {
        StGuard = 1'b0,
        StOn    = 1'b1
    } slot_state_e;

    localparam int unsigned DefaultRefreshDiv  = 100000;
    localparam int unsigned DefaultGuardCycles = 500;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// Host-side and decoder-side signals of the scan driver.
// The master drives load/value; the slave (driver) returns the scan outputs.
interface seven_segment_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  pending;
    logic                  x3;
    logic                  x2;
    logic                  x1;
    logic                  x0;
    logic [DIGITS-1:0]     an;
    logic                  blank;

    modport master (
        output load, value,
        input  pending, x3, x2, x1, x0, an, blank
    );

    modport slave (
        input  load, value,
        output pending, x3, x2, x1, x0, an, blank
    );

endinterface

// File: rtl/seven_segment_scan_driver_scan_slot_timer.sv
// Slot timer: counts cycles within a digit slot, tracks GUARD/ON and the digit index.
// Exposes next-state values so the output registers stay aligned with the slot.
module scan_slot_timer
    import seven_segment_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = DefaultRefreshDiv,
    parameter int unsigned GUARD_CYCLES = DefaultGuardCycles
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         o_slot_end,
    output logic [width_for(DIGITS)-1:0] o_idx,
    output logic [width_for(DIGITS)-1:0] o_idx_next,
    output logic                         o_on_next
);

    localparam int unsigned CntW = width_for(REFRESH_DIV);
    localparam int unsigned IdxW = width_for(DIGITS);
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [IdxW-1:0] r_idx;
    logic [IdxW-1:0] w_idx_d;
    slot_state_e     r_state;
    slot_state_e     w_state_d;

    always_comb begin
        o_slot_end = (r_cnt == CntLast);
        w_cnt_d    = o_slot_end ? '0 : r_cnt + CntW'(1);
        w_idx_d    = r_idx;
        if (o_slot_end) begin
            w_idx_d = (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
        end
        w_state_d = r_state;
        unique case (r_state)
            StGuard: w_state_d = (32'(w_cnt_d) >= GUARD_CYCLES) ? StOn : StGuard;
            StOn: begin
                if (o_slot_end && (GUARD_CYCLES != 0)) begin
                    w_state_d = StGuard;
                end
            end
            default: w_state_d = StGuard;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= StGuard;
        end else begin
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_state <= w_state_d;
        end
    end

    assign o_idx      = r_idx;
    assign o_idx_next = w_idx_d;
    assign o_on_next  = (w_state_d == StOn);

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexes a BCD value onto one shared seven-segment decoder with guard gaps,
// leading-zero blanking and frame-boundary commit of newly loaded values.
module seven_segment_scan_driver
    import seven_segment_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = DefaultRefreshDiv,
    parameter int unsigned GUARD_CYCLES = DefaultGuardCycles,
    parameter int unsigned BLANK_ZEROS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seven_segment_scan_driver_if.slave  bus
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = width_for(DIGITS);

    logic [W-1:0]      r_display;
    logic [W-1:0]      w_display_d;
    logic [W-1:0]      r_pend_val;
    logic [W-1:0]      w_pend_val_d;
    logic              r_pending;
    logic              w_pending_d;
    logic              w_slot_end;
    logic              w_on_next;
    logic [IdxW-1:0]   w_idx;
    logic [IdxW-1:0]   w_idx_next;
    logic              w_commit;
    logic [3:0]        w_nibble;
    logic              w_blanked;
    logic              w_zero_acc;
    logic [DIGITS-1:0] w_an_d;
    logic [DIGITS-1:0] r_an;
    logic [3:0]        r_x;
    logic              r_blank;

    scan_slot_timer #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_slot_end (w_slot_end),
        .o_idx      (w_idx),
        .o_idx_next (w_idx_next),
        .o_on_next  (w_on_next)
    );

    // Display only changes as the last digit's slot hands back to digit 0.
    always_comb begin
        w_commit     = w_slot_end && (w_idx == IdxW'(DIGITS - 1));
        w_display_d  = r_display;
        w_pend_val_d = r_pend_val;
        w_pending_d  = r_pending;
        if (bus.load) begin
            w_pend_val_d = bus.value;
            w_pending_d  = 1'b1;
        end
        if (w_commit) begin
            if (bus.load) begin
                w_display_d = bus.value;
            end else if (r_pending) begin
                w_display_d = r_pend_val;
            end
            w_pending_d = 1'b0;
        end
    end

    // Walk from the top digit down so w_zero_acc means "this digit and all above are zero".
    always_comb begin
        w_zero_acc = 1'b1;
        w_nibble   = 4'h0;
        w_blanked  = 1'b0;
        w_an_d     = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_acc = w_zero_acc && (w_display_d[4*i +: 4] == 4'h0);
            if (IdxW'(i) == w_idx_next) begin
                w_nibble  = w_display_d[4*i +: 4];
                w_blanked = (BLANK_ZEROS != 0) && (i != 0) && w_zero_acc;
                w_an_d[i] = ~(w_on_next && !w_blanked);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display  <= '0;
            r_pend_val <= '0;
            r_pending  <= 1'b0;
            r_an       <= '1;
            r_x        <= 4'h0;
            r_blank    <= 1'b1;
        end else begin
            r_display  <= w_display_d;
            r_pend_val <= w_pend_val_d;
            r_pending  <= w_pending_d;
            r_an       <= w_an_d;
            r_x        <= w_nibble;
            r_blank    <= !w_on_next || w_blanked;
        end
    end

    assign bus.pending = r_pending;
    assign bus.x3      = r_x[3];
    assign bus.x2      = r_x[2];
    assign bus.x1      = r_x[1];
    assign bus.x0      = r_x[0];
    assign bus.an      = r_an;
    assign bus.blank   = r_blank;

endmodule
